// File: rtl/bus_arbiter_3way_pkg.sv
// Shared encodings for the 3-way bus arbiter: FSM states, owner indices,
// shared-path select codes and the round-robin helpers.
package bus_arbiter_3way_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] OWN_X = 2'd0;
    localparam logic [1:0] OWN_Y = 2'd1;
    localparam logic [1:0] OWN_Z = 2'd2;

    localparam logic [1:0] SEL_X = 2'b00;
    localparam logic [1:0] SEL_Y = 2'b10;
    localparam logic [1:0] SEL_Z = 2'b11;

    function automatic logic [1:0] next_owner(input logic [1:0] idx);
        case (idx)
            OWN_X:   next_owner = OWN_Y;
            OWN_Y:   next_owner = OWN_Z;
            default: next_owner = OWN_X;
        endcase
    endfunction

    // Search starts one past the previous owner, so no requester is favoured.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        c0 = next_owner(last);
        c1 = next_owner(c0);
        c2 = next_owner(c1);
        if (req[c0]) begin
            rr_pick = c0;
        end else if (req[c1]) begin
            rr_pick = c1;
        end else begin
            rr_pick = c2;
        end
    endfunction

    function automatic logic [1:0] owner_to_sel(input logic [1:0] idx);
        case (idx)
            OWN_X:   owner_to_sel = SEL_X;
            OWN_Y:   owner_to_sel = SEL_Y;
            default: owner_to_sel = SEL_Z;
        endcase
    endfunction

    function automatic logic [2:0] owner_to_gnt(input logic [1:0] idx);
        case (idx)
            OWN_X:   owner_to_gnt = 3'b001;
            OWN_Y:   owner_to_gnt = 3'b010;
            default: owner_to_gnt = 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_3way_mux4way16.sv
// Mux4Way16: 16-bit 4-input selector for the shared bus path.
module bus_arbiter_3way_mux4way16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    input  logic [15:0] d_i,
    input  logic [1:0]  sel_i,
    output logic [15:0] out_o
);

    // Pick one of four words by the select code.
    always_comb begin
        out_o = a_i;
        case (sel_i)
            2'b00:   out_o = a_i;
            2'b01:   out_o = b_i;
            2'b10:   out_o = c_i;
            2'b11:   out_o = d_i;
            default: out_o = a_i;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_3way.sv
// Three-requester round-robin bus arbiter with burst cap and a registered
// shared 16-bit data path.
module bus_arbiter_3way
    import bus_arbiter_3way_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] din_x,
    input  logic [15:0] din_y,
    input  logic [15:0] din_z,
    output logic [2:0]  gnt,
    output logic [1:0]  sel,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        busy
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_e      state_q;
    logic [2:0]  gnt_q;
    logic [1:0]  sel_q;
    logic [1:0]  owner_q;
    logic [1:0]  last_owner_q;
    logic [3:0]  cnt_q;
    logic [15:0] dout_q;
    logic        dout_valid_q;
    logic        busy_q;
    logic [1:0]  winner_d;
    logic [15:0] mux_word;

    assign winner_d = rr_pick(req, last_owner_q);

    // The 2'b01 leg is never selected; tie it off.
    bus_arbiter_3way_mux4way16 u_mux4way16 (
        .a_i   (din_x),
        .b_i   (16'h0000),
        .c_i   (din_y),
        .d_i   (din_z),
        .sel_i (sel_q),
        .out_o (mux_word)
    );

    // Arbitration FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 3'b000;
            sel_q        <= SEL_X;
            owner_q      <= OWN_X;
            last_owner_q <= OWN_Z;
            cnt_q        <= 4'd0;
            dout_q       <= 16'h0000;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dout_valid_q <= 1'b0;
                    if (req != 3'b000) begin
                        owner_q <= winner_d;
                        gnt_q   <= owner_to_gnt(winner_d);
                        sel_q   <= owner_to_sel(winner_d);
                        cnt_q   <= 4'd0;
                        state_q <= ST_GRANT;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q <= 3'b000;
                    end
                end
                ST_GRANT: begin
                    if (req[owner_q]) begin
                        dout_q       <= mux_word;
                        dout_valid_q <= 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q      <= ST_IDLE;
                            gnt_q        <= 3'b000;
                            busy_q       <= 1'b0;
                            last_owner_q <= owner_q;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        dout_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                        gnt_q        <= 3'b000;
                        busy_q       <= 1'b0;
                        last_owner_q <= owner_q;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    gnt_q        <= 3'b000;
                    dout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bus_arbiter_3way.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level reference model of the arbiter.
module tb_bus_arbiter_3way;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] din_x, din_y, din_z;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;

    always #5 clk = ~clk;

    bus_arbiter_3way #(.MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din_x      (din_x),
        .din_y      (din_y),
        .din_z      (din_z),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, how many words it has moved.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_words;
    logic [2:0]  m_gnt;
    logic [1:0]  m_sel;
    logic [15:0] m_dout;
    logic        m_valid;
    logic [1:0]  sel_code [3] = '{2'b00, 2'b10, 2'b11};

    logic [1:0]  grant_sels [$];
    logic [15:0] words [$];
    logic [2:0]  gnt_prev;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [2:0] rq,
                              input logic [15:0] dx, input logic [15:0] dy, input logic [15:0] dz);
        logic [15:0] d [3];
        bit found;
        d[0] = dx; d[1] = dy; d[2] = dz;
        if (r) begin
            m_busy = 0; m_gnt = 3'b000; m_sel = 2'b00; m_dout = 16'h0000;
            m_valid = 1'b0; m_last = 2; m_words = 0; m_owner = 0;
        end else if (!m_busy) begin
            m_valid = 1'b0;
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (!found && rq[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_busy  = 1;
                    m_words = 0;
                    m_gnt   = 3'(1 << c);
                    m_sel   = sel_code[c];
                end
            end
            if (!found) m_gnt = 3'b000;
        end else begin
            if (rq[m_owner]) begin
                m_dout  = d[m_owner];
                m_valid = 1'b1;
                m_words++;
                if (m_words == MAX_BURST) begin
                    m_busy = 0; m_gnt = 3'b000; m_last = m_owner;
                end
            end else begin
                m_valid = 1'b0;
                m_busy = 0; m_gnt = 3'b000; m_last = m_owner;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [2:0] rq,
                        input logic [15:0] dx, input logic [15:0] dy, input logic [15:0] dz);
        rst = r; req = rq; din_x = dx; din_y = dy; din_z = dz;
        model_step(r, rq, dx, dy, dz);
        @(posedge clk);
        #1;
        check("gnt",        {13'd0, gnt},        {13'd0, m_gnt});
        check("sel",        {14'd0, sel},        {14'd0, m_sel});
        check("dout",       dout,                m_dout);
        check("dout_valid", {15'd0, dout_valid}, {15'd0, m_valid});
        check("busy",       {15'd0, busy},       {15'd0, m_busy});
        check("gnt_onehot0", {15'd0, $onehot0(gnt)}, 16'd1);
        if (gnt != 3'b000) begin
            check("sel_vs_gnt", {14'd0, sel},
                  {14'd0, gnt[0] ? 2'b00 : (gnt[1] ? 2'b10 : 2'b11)});
        end
        if (gnt_prev == 3'b000 && gnt != 3'b000) grant_sels.push_back(sel);
        if (dout_valid) words.push_back(dout);
        gnt_prev = gnt;
    endtask

    task automatic do_reset();
        tick(1'b1, 3'b000, 16'h0, 16'h0, 16'h0);
        tick(1'b1, 3'b111, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        int ycount;
        logic [2:0] rq;
        rst = 1'b1; req = 3'b000; din_x = 16'h0; din_y = 16'h0; din_z = 16'h0;
        gnt_prev = 3'b000;
        m_busy = 0; m_owner = 0; m_last = 2; m_words = 0;
        m_gnt = 3'b000; m_sel = 2'b00; m_dout = 16'h0; m_valid = 1'b0;

        // Reset then all three requesting: x first, then y, z, x, four words each.
        do_reset();
        check("reset_dout", dout, 16'h0000);
        grant_sels.delete();
        tick(1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333);
        check("first_gnt_x", {13'd0, gnt}, 16'h0001);
        for (int i = 0; i < 19; i++)
            tick(1'b0, 3'b111, 16'(i + 16'h100), 16'(i + 16'h200), 16'(i + 16'h300));
        check("rr_grants", 16'(grant_sels.size()), 16'd4);
        if (grant_sels.size() == 4) begin
            check("rr_sel0", {14'd0, grant_sels[0]}, 16'd0);
            check("rr_sel1", {14'd0, grant_sels[1]}, 16'd2);
            check("rr_sel2", {14'd0, grant_sels[2]}, 16'd3);
            check("rr_sel3", {14'd0, grant_sels[3]}, 16'd0);
        end

        // Burst cap: y alone, data counting up per transferred word.
        do_reset();
        words.delete();
        ycount = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 3'b010, 16'hdead, 16'(ycount + 1), 16'hbeef);
            if (m_valid) ycount++;
            if (i == 4) check("burst_gnt_drop", {13'd0, gnt}, 16'd0);
        end
        check("burst_regrant_y", {13'd0, gnt}, 16'h0002);
        check("burst_words", 16'(words.size()), 16'd4);
        for (int i = 0; i < 4 && i < words.size(); i++)
            check("burst_word", words[i], 16'(i + 1));

        // Early release by z after two words; pending x wins over y next.
        do_reset();
        words.delete();
        tick(1'b0, 3'b100, 16'h0, 16'h0, 16'h0);
        tick(1'b0, 3'b100, 16'h0, 16'h0, 16'hc001);
        tick(1'b0, 3'b100, 16'h0, 16'h0, 16'hc002);
        tick(1'b0, 3'b011, 16'h0, 16'h0, 16'hc003);
        check("early_gnt_drop", {13'd0, gnt}, 16'd0);
        check("early_words", 16'(words.size()), 16'd2);
        tick(1'b0, 3'b011, 16'h0, 16'h0, 16'h0);
        check("early_x_wins", {13'd0, gnt}, 16'h0001);

        // Reset during y's second transfer cycle.
        do_reset();
        tick(1'b0, 3'b010, 16'h0, 16'h0, 16'h0);
        tick(1'b0, 3'b010, 16'h0, 16'haaaa, 16'h0);
        tick(1'b1, 3'b010, 16'h0, 16'h5555, 16'h0);
        check("midrst_gnt",   {13'd0, gnt}, 16'd0);
        check("midrst_valid", {15'd0, dout_valid}, 16'd0);
        check("midrst_dout",  dout, 16'h0000);

        // Random traffic with sticky requests and occasional reset.
        rq = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rq = 3'($urandom_range(7));
            tick(($urandom_range(63) == 0) ? 1'b1 : 1'b0, rq,
                 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
